mmio_io_bridge: RTL and testbench
=================================

// Module: mmio_io_bridge
// PURPOSE
//  Memory-mapped I/O bridge between the single-cycle CPU datapath and board peripherals.
//  Sits beside dmemory32: merges switch/button/test inputs and RAM read data into one load-result bus.
//  Holds the registered 7-seg, LED and blink outputs that feed the display driver.
//  Control decides IORead/IOWrite from address bits [31:10] == 22'h3FFFFF (IO region 0xFFFFFC00+).
// PARAMETERS
//  SEG_W    24  width of 7-seg data register
//  LED_W    24  width of LED data register
// PORTS
//  clk             in   1   CPU clock; all state updates on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  IORead          in   1   load targets IO region (from control32)
//  IOWrite         in   1   store targets IO region (from control32)
//  ALU_result      in   32  effective address
//  Read_data_2     in   32  store data (rt)
//  MemReadData     in   32  data-RAM read data
//  IO_input        in   8   switches [7:0]
//  TEST_input      in   3   test-case select switches
//  enterA          in   1   debounced button A pulse
//  enterB          in   1   debounced button B pulse
//  MemorIO_Result  out  32  load result to register file
//  IO_seg_out      out  SEG_W  7-seg data
//  IO_led_out      out  LED_W  LED data
//  IO_blink_out    out  1   blink request
// BEHAVIOUR
//  Offset decode uses ALU_result[7:2]; bits [1:0] ignored. Register map (offset from 0xFFFFFC00):
//   0x00 R: {24'b0, IO_input}    0x04 R: {29'b0, TEST_input}
//   0x08 R: {31'b0, flagA}; W(any): clear flagA    0x0C same for flagB/enterB
//   0x10 W: seg <= Read_data_2[SEG_W-1:0]    0x14 W: led <= Read_data_2[LED_W-1:0]
//   0x18 W: blink <= Read_data_2[0]
//  MemorIO_Result combinational: IORead ? io_rdata : MemReadData; zero latency.
//  Reads of unmapped offsets -> 32'h0. Writes to unmapped/read-only offsets ignored.
//  Writes take effect at the rising clk edge where IOWrite=1; visible on outputs next cycle.
//  flagA/flagB: set on clk edge where enterA/enterB=1; cleared by IO write to their offset.
//  Simultaneous set and clear in the same cycle: set wins (flag stays 1).
//  IOWrite=0: no register changes; IORead and IOWrite both 1 (illegal): write performed, read muxed.
//  rst_n=0 (async, any time): seg, led, blink, flagA, flagB -> 0 immediately; outputs 0.
//  MemorIO_Result is not reset (pure mux).
// CONFIGURATION
//  IO_READBACK_EN defined: offsets 0x10/0x14/0x18 also readable, returning
//   zero-extended seg, led, {31'b0,blink}.
//  Not defined: those offsets read 32'h0 (write-only).
// TESTING
//  Reset: rst_n=0 mid-run -> IO_seg_out=0, IO_led_out=0, IO_blink_out=0 without clk edge.
//  IO_input=8'hA5, IORead=1, addr 0xFFFFFC00 -> MemorIO_Result=32'h000000A5; IORead=0 -> =MemReadData.
//  IOWrite=1, addr 0xFFFFFC14, data 32'hDEADBEEF -> IO_led_out=24'hADBEEF after edge; unmapped 0xFFFFFC3C write -> no change.
//  enterA pulse one cycle -> read 0xFFFFFC08 = 1; write 0xFFFFFC08 -> reads 0; pulse+write same cycle -> stays 1.
//  TEST_input=3'b101 read 0xFFFFFC04 -> 32'h5; read 0xFFFFFC10 after writing seg=24'h123456 -> 32'h00123456
//   with IO_READBACK_EN, 32'h0 without.

Source files
------------

// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge: merges peripheral reads with data-RAM reads and holds the 7-seg/LED/blink registers.
// Optional IO_READBACK_EN makes the seg/led/blink offsets readable; the default build leaves them write-only.
module mmio_io_bridge #(
  parameter int SEG_W = 24,
  parameter int LED_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IORead,
  input  logic             IOWrite,
  input  logic [31:0]      ALU_result,
  input  logic [31:0]      Read_data_2,
  input  logic [31:0]      MemReadData,
  input  logic [7:0]       IO_input,
  input  logic [2:0]       TEST_input,
  input  logic             enterA,
  input  logic             enterB,
  output logic [31:0]      MemorIO_Result,
  output logic [SEG_W-1:0] IO_seg_out,
  output logic [LED_W-1:0] IO_led_out,
  output logic             IO_blink_out
);

  typedef enum logic [5:0] {
    OFF_SWITCH = 6'h00,
    OFF_TEST   = 6'h01,
    OFF_FLAGA  = 6'h02,
    OFF_FLAGB  = 6'h03,
    OFF_SEG    = 6'h04,
    OFF_LED    = 6'h05,
    OFF_BLINK  = 6'h06
  } io_off_e;

  io_off_e          w_off;
  logic             w_wr_seg;
  logic             w_wr_led;
  logic             w_wr_blink;
  logic             w_clr_a;
  logic             w_clr_b;
  logic [31:0]      w_io_rdata;
  logic             w_unused;

  logic [SEG_W-1:0] r_seg;
  logic [LED_W-1:0] r_led;
  logic             r_blink;
  logic             r_flag_a;
  logic             r_flag_b;

  // Word offset within the IO page; byte-lane bits and page bits are not decoded here.
  assign w_off    = io_off_e'(ALU_result[7:2]);
  assign w_unused = ^{ALU_result[31:8], ALU_result[1:0], Read_data_2};

  always_comb begin
    w_wr_seg   = 1'b0;
    w_wr_led   = 1'b0;
    w_wr_blink = 1'b0;
    w_clr_a    = 1'b0;
    w_clr_b    = 1'b0;
    if (IOWrite) begin
      case (w_off)
        OFF_SEG:   w_wr_seg   = 1'b1;
        OFF_LED:   w_wr_led   = 1'b1;
        OFF_BLINK: w_wr_blink = 1'b1;
        OFF_FLAGA: w_clr_a    = 1'b1;
        OFF_FLAGB: w_clr_b    = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= '0;
      r_led   <= '0;
      r_blink <= 1'b0;
    end else begin
      if (w_wr_seg)   r_seg   <= Read_data_2[SEG_W-1:0];
      if (w_wr_led)   r_led   <= Read_data_2[LED_W-1:0];
      if (w_wr_blink) r_blink <= Read_data_2[0];
    end
  end

  // A button press arriving in the same cycle as a clear must not be lost, so set dominates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
    end else begin
      if (enterA)       r_flag_a <= 1'b1;
      else if (w_clr_a) r_flag_a <= 1'b0;
      if (enterB)       r_flag_b <= 1'b1;
      else if (w_clr_b) r_flag_b <= 1'b0;
    end
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_off)
      OFF_SWITCH: w_io_rdata = {24'b0, IO_input};
      OFF_TEST:   w_io_rdata = {29'b0, TEST_input};
      OFF_FLAGA:  w_io_rdata = {31'b0, r_flag_a};
      OFF_FLAGB:  w_io_rdata = {31'b0, r_flag_b};
`ifdef IO_READBACK_EN
      OFF_SEG:    w_io_rdata = 32'(r_seg);
      OFF_LED:    w_io_rdata = 32'(r_led);
      OFF_BLINK:  w_io_rdata = {31'b0, r_blink};
`else
      OFF_SEG, OFF_LED, OFF_BLINK: w_io_rdata = '0;
`endif
      default:    w_io_rdata = '0;
    endcase
  end

  assign MemorIO_Result = IORead ? w_io_rdata : MemReadData;
  assign IO_seg_out     = r_seg;
  assign IO_led_out     = r_led;
  assign IO_blink_out   = r_blink;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed self-checking bench for mmio_io_bridge; expectations follow the IO register map.
module tb_mmio_io_bridge;

`ifdef IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IORead, IOWrite;
  logic [31:0] ALU_result, Read_data_2, MemReadData;
  logic [7:0]  IO_input;
  logic [2:0]  TEST_input;
  logic        enterA, enterB;
  logic [31:0] MemorIO_Result;
  logic [23:0] IO_seg_out, IO_led_out;
  logic        IO_blink_out;

  int total = 0;
  int bad   = 0;

  mmio_io_bridge #(.SEG_W(24), .LED_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .IORead(IORead), .IOWrite(IOWrite),
    .ALU_result(ALU_result), .Read_data_2(Read_data_2), .MemReadData(MemReadData),
    .IO_input(IO_input), .TEST_input(TEST_input), .enterA(enterA), .enterB(enterB),
    .MemorIO_Result(MemorIO_Result), .IO_seg_out(IO_seg_out), .IO_led_out(IO_led_out),
    .IO_blink_out(IO_blink_out)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    IOWrite = 1'b1; ALU_result = addr; Read_data_2 = data;
    @(posedge clk); #1;
    IOWrite = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] res);
    @(negedge clk);
    IORead = 1'b1; ALU_result = addr;
    #1 res = MemorIO_Result;
    IORead = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; IORead = 0; IOWrite = 0; ALU_result = '0; Read_data_2 = '0;
    MemReadData = 32'h1234_5678; IO_input = '0; TEST_input = '0; enterA = 0; enterB = 0;
    #2;
    total++;
    if ({IO_seg_out, IO_led_out, IO_blink_out} !== 49'h0) begin
      bad++; $display("FAIL reset_outputs: got seg=%h led=%h blink=%b, want all 0", IO_seg_out, IO_led_out, IO_blink_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_io_read;
    logic [31:0] r;
    IO_input = 8'hA5;
    do_read(32'hFFFF_FC00, r);
    total++;
    if (r !== 32'h0000_00A5) begin bad++; $display("FAIL switch_read: got %h want 000000a5", r); end
    @(negedge clk); IORead = 0; ALU_result = 32'hFFFF_FC00; MemReadData = 32'hCAFE_F00D; #1;
    total++;
    if (MemorIO_Result !== 32'hCAFE_F00D) begin bad++; $display("FAIL mem_passthru: got %h want cafef00d", MemorIO_Result); end
    TEST_input = 3'b101;
    do_read(32'hFFFF_FC04, r);
    total++;
    if (r !== 32'h5) begin bad++; $display("FAIL test_input_read: got %h want 00000005", r); end
    do_read(32'hFFFF_FC07, r);
    total++;
    if (r !== 32'h5) begin bad++; $display("FAIL byte_bits_ignored: got %h want 00000005", r); end
    do_read(32'hFFFF_FC1C, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want 00000000", r); end
  endtask

  task automatic test_led_write;
    do_write(32'hFFFF_FC14, 32'hDEAD_BEEF);
    total++;
    if (IO_led_out !== 24'hADBEEF) begin bad++; $display("FAIL led_write: got %h want adbeef", IO_led_out); end
    do_write(32'hFFFF_FC3C, 32'h1111_1111);
    do_write(32'hFFFF_FC00, 32'h2222_2222);
    total++;
    if (IO_led_out !== 24'hADBEEF || IO_seg_out !== 24'h0 || IO_blink_out !== 1'b0) begin
      bad++; $display("FAIL ignored_writes: got led=%h seg=%h blink=%b want adbeef/000000/0", IO_led_out, IO_seg_out, IO_blink_out);
    end
    @(negedge clk); IOWrite = 0; ALU_result = 32'hFFFF_FC14; Read_data_2 = 32'h0055_5555;
    @(posedge clk); #1;
    total++;
    if (IO_led_out !== 24'hADBEEF) begin bad++; $display("FAIL no_write_when_idle: got %h want adbeef", IO_led_out); end
  endtask

  task automatic test_flags;
    logic [31:0] r;
    @(negedge clk); enterA = 1'b1; @(posedge clk); #1; enterA = 1'b0;
    do_read(32'hFFFF_FC08, r);
    total++;
    if (r !== 32'h1) begin bad++; $display("FAIL flagA_set: got %h want 00000001", r); end
    do_read(32'hFFFF_FC0C, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL flagB_idle: got %h want 00000000", r); end
    do_write(32'hFFFF_FC08, 32'h0);
    do_read(32'hFFFF_FC08, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL flagA_clear: got %h want 00000000", r); end
    @(negedge clk); enterA = 1'b1; IOWrite = 1'b1; ALU_result = 32'hFFFF_FC08;
    @(posedge clk); #1; enterA = 1'b0; IOWrite = 1'b0;
    do_read(32'hFFFF_FC08, r);
    total++;
    if (r !== 32'h1) begin bad++; $display("FAIL flagA_set_wins: got %h want 00000001", r); end
    @(negedge clk); enterB = 1'b1; @(posedge clk); #1; enterB = 1'b0;
    do_read(32'hFFFF_FC0C, r);
    total++;
    if (r !== 32'h1) begin bad++; $display("FAIL flagB_set: got %h want 00000001", r); end
    do_write(32'hFFFF_FC0C, 32'hFFFF_FFFF);
    do_read(32'hFFFF_FC0C, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL flagB_clear: got %h want 00000000", r); end
    do_read(32'hFFFF_FC08, r);
    total++;
    if (r !== 32'h1) begin bad++; $display("FAIL flagA_untouched: got %h want 00000001", r); end
  endtask

  task automatic test_readback;
    logic [31:0] r;
    do_write(32'hFFFF_FC10, 32'hFF12_3456);
    total++;
    if (IO_seg_out !== 24'h123456) begin bad++; $display("FAIL seg_write: got %h want 123456", IO_seg_out); end
    do_read(32'hFFFF_FC10, r);
    total++;
    if (r !== (RB ? 32'h0012_3456 : 32'h0)) begin
      bad++; $display("FAIL seg_readback: got %h want %h", r, RB ? 32'h0012_3456 : 32'h0);
    end
    do_read(32'hFFFF_FC14, r);
    total++;
    if (r !== (RB ? 32'h00AD_BEEF : 32'h0)) begin
      bad++; $display("FAIL led_readback: got %h want %h", r, RB ? 32'h00AD_BEEF : 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    // Read and write asserted together on the blink register.
    @(negedge clk); IORead = 1'b1; IOWrite = 1'b1; ALU_result = 32'hFFFF_FC18; Read_data_2 = 32'h0000_0003;
    @(posedge clk); #1; IOWrite = 1'b0;
    total++;
    if (IO_blink_out !== 1'b1) begin bad++; $display("FAIL blink_rw_both: got %b want 1", IO_blink_out); end
    total++;
    if (MemorIO_Result !== (RB ? 32'h1 : 32'h0)) begin
      bad++; $display("FAIL blink_read_mux: got %h want %h", MemorIO_Result, RB ? 32'h1 : 32'h0);
    end
    IORead = 1'b0;
    do_write(32'hFFFF_FC10, 32'h0000_ABCD);
    do_write(32'hFFFF_FC14, 32'h0001_2345);
    do_write(32'hFFFF_FC18, 32'h0000_0002);
    total++;
    if (IO_seg_out !== 24'h00ABCD || IO_led_out !== 24'h012345 || IO_blink_out !== 1'b0) begin
      bad++; $display("FAIL back_to_back: got seg=%h led=%h blink=%b want 00abcd/012345/0", IO_seg_out, IO_led_out, IO_blink_out);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] r;
    do_write(32'hFFFF_FC18, 32'h1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    total++;
    if ({IO_seg_out, IO_led_out, IO_blink_out} !== 49'h0) begin
      bad++; $display("FAIL async_reset: got seg=%h led=%h blink=%b want all 0", IO_seg_out, IO_led_out, IO_blink_out);
    end
    @(negedge clk); rst_n = 1'b1;
    do_read(32'hFFFF_FC08, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL flagA_after_reset: got %h want 00000000", r); end
  endtask

  initial begin
    test_reset();
    test_io_read();
    test_led_write();
    test_flags();
    test_readback();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
